inst_mem_fetch: RTL
===================

Name: inst_mem_fetch

Overview:
Parametrised, synchronous-read instruction memory with a valid/ready fetch handshake, a one-entry registered response stage, a runtime program-load port and a flush input for redirects. It replaces the combinational instruction ROM in the single-cycle and pipelined datapaths. It sits between the PC/fetch stage and the decode stage. Out-of-range and misaligned fetches are flagged and answered with a NOP instead of aliasing.

Parameters:
WIDTH, 32, instruction word width in bits
DEPTH, 256, number of words; power of two, at least 4
ADDR_W, 32, byte-address width of the fetch and load ports
IDX_W, $clog2(DEPTH), word-index width; derived, do not override

Ports:
Clk  in  1  clock; all state updates on the rising edge
Rst  in  1  asynchronous, active-high reset
ReqValid  in  1  fetch request present
ReqReady  out  1  block can accept a fetch this cycle
ReqAddr  in  ADDR_W  byte address of the fetch
RespValid  out  1  response register holds a valid instruction
RespReady  in  1  consumer takes the response this cycle
RespInst  out  WIDTH  fetched instruction (0 = NOP on error)
RespAddr  out  ADDR_W  byte address that produced RespInst
RespErr  out  1  fetch was misaligned or out of range
Flush  in  1  discard the pending response and any request accepted this cycle
LoadEn  in  1  write one word into memory
LoadAddr  in  ADDR_W  byte address of the write
LoadData  in  WIDTH  word to write
LoadErr  out  1  sticky flag: a load was misaligned or out of range

Behaviour:
- Memory array: DEPTH x WIDTH. Every word is set to 0 at time zero. Rst does NOT clear memory contents.
- Reset: RespValid=0, RespInst=0, RespAddr=0, RespErr=0, LoadErr=0.
- ReqReady = !LoadEn && (!RespValid || RespReady). This is combinational, so a load always wins and fetch and write never share a cycle.
- Accept: a request is accepted on a cycle where ReqValid && ReqReady && !Flush.
- Accept timing: on the next edge RespValid=1 and RespAddr=ReqAddr. This is exactly one cycle of latency.
- Fetch error: ReqAddr[1:0]!=0, or ReqAddr[ADDR_W-1:2] >= DEPTH.
  - On error: RespErr=1 and RespInst=0.
  - Otherwise: RespErr=0 and RespInst=mem[ReqAddr[IDX_W+1:2]].
- Consume: on an edge where RespValid && RespReady and no new accept, RespValid goes to 0.
- Back-to-back: consume and accept in the same cycle give one response per cycle with no bubble.
- Stall: while RespValid && !RespReady, RespInst, RespAddr and RespErr hold stable. ReqReady=0 during the stall.
- Flush has priority over everything:
  - On the next edge RespValid=0, and any same-cycle request is dropped.
  - RespInst, RespAddr and RespErr may keep their stale values.
  - ReqReady is not gated by Flush; the request is simply not accepted.
- Load:
  - In range and aligned: mem[LoadAddr[IDX_W+1:2]] <= LoadData on the edge.
  - Misaligned or out of range: no write, and LoadErr <= 1. LoadErr stays set until Rst.
  - A fetch of the same address on the cycle after a load returns the new data.
- Load during a pending response: the response register is unaffected. A held response keeps its pre-load data.
- Rst mid-operation: the pending response is lost immediately (asynchronous). Memory keeps its contents.
- Word-index wrap is impossible: out-of-range indices are rejected, never truncated.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INST constant (WIDTH'b0)
  - idx_of() and addr_ok() helper functions
  - default WIDTH/DEPTH constants shared with the data memory
- One sub-module, mem_sp_1r1w: a DEPTH x WIDTH array with a synchronous read port, a write port and the zero initialisation. It is reused later for the data memory.
- inst_mem_fetch holds the handshake, flush, error and response-register logic.

Test Plan:
- Basic fetch, after Rst (DEPTH=256): load 0x34010005 at 0x0 and 0x34020003 at 0x4, then fetch 0x0 and 0x4 back-to-back with RespReady=1 -> responses on consecutive cycles: (0x0, 0x34010005, Err=0), then (0x4, 0x34020003, Err=0). ReqReady stays 1.
- Backpressure: fetch 0x4 with RespReady=0 for 3 cycles -> RespValid=1 and RespInst=0x34020003 held stable, ReqReady=0. RespReady=1 -> consumed; ReqReady rises in that same cycle.
- Errors: fetch 0x2 -> RespErr=1, RespInst=0. Fetch 0x400 -> RespErr=1, RespInst=0. Load to 0x401 -> LoadErr=1 with no memory change; LoadErr stays 1 until Rst.
- Flush: accept fetch 0x8, then assert Flush with a new request at 0xC -> next cycle RespValid=0, and 0xC produces no response.
- Load priority / RAW: LoadEn with ReqValid=1 -> ReqReady=0. Next cycle fetch the same address -> returns the newly loaded word.
- Async reset mid-stall: assert Rst between edges while RespValid=1 -> RespValid=0 immediately. A fetch of 0x0 after deassert returns 0x34010005 (memory retained).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the instruction and data memories.
// Provides the default memory geometry, the NOP encoding and the address
// helpers that turn a byte address into a word index and decide whether it
// is legal for a given memory depth.
// Addresses are widened to MAX_ADDR_W bits before the helpers are called.
// This lets one function serve every ADDR_W up to that limit.
package cpu_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_ADDR_W = 32;

    localparam int MAX_ADDR_W = 64;
    localparam int MAX_WIDTH  = 64;

    // All-zero word; the consumer treats it as a NOP. Slice to the data width in use.
    localparam logic [MAX_WIDTH-1:0] NOP_INST = '0;

    // Word index of a byte address (word = 4 bytes).
    function automatic logic [MAX_ADDR_W-1:0] idx_of(input logic [MAX_ADDR_W-1:0] addr);
        return addr >> 2;
    endfunction

    // Legal only when word-aligned and inside the array. The compare is done
    // on the full index, so an out-of-range address can never wrap onto a
    // low word.
    function automatic logic addr_ok(input logic [MAX_ADDR_W-1:0] addr,
                                     input int unsigned           depth);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < {32'd0, depth});
    endfunction

endpackage

// File: rtl/mem_sp_1r1w.sv
// Single-port-style DEPTH x WIDTH memory with one synchronous read port and
// one write port. Every word starts at zero. There is no reset: the contents
// survive a system reset.
// Ports:
//   clk      - clock, all activity on the rising edge
//   we       - write enable
//   wr_idx   - word index to write
//   wr_data  - word to write
//   re       - read enable; rd_data only changes on an enabled read
//   rd_idx   - word index to read
//   rd_data  - registered read data, held between enabled reads
module mem_sp_1r1w #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] rd_data_q   = '0;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Reads are registered and only update when enabled. A later write cannot
    // disturb a word that has already been read out.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_mem_fetch.sv
// Instruction memory with a valid/ready fetch handshake and a one-entry
// registered response stage. It sits between the PC/fetch stage and decode.
// A runtime load port writes program words. Flush drops the pending response
// and any request offered in the same cycle. Misaligned or out-of-range
// fetches return a NOP with RespErr set. Bad loads set the sticky LoadErr.
// Ports:
//   Clk, Rst            - clock; asynchronous active-high reset
//   ReqValid/ReqReady   - fetch handshake, ReqAddr is the byte address
//   RespValid/RespReady - response handshake
//   RespInst/RespAddr   - fetched word and the address that produced it
//   RespErr             - the fetch was misaligned or out of range
//   Flush               - redirect: discard the pending and same-cycle work
//   LoadEn/LoadAddr/LoadData - program-load write port
//   LoadErr             - sticky: some load was misaligned or out of range
module inst_mem_fetch
    import cpu_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int ADDR_W = DEF_ADDR_W,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [ADDR_W-1:0] ReqAddr,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [WIDTH-1:0]  RespInst,
    output logic [ADDR_W-1:0] RespAddr,
    output logic              RespErr,
    input  logic              Flush,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [WIDTH-1:0]  LoadData,
    output logic              LoadErr
);

    logic [MAX_ADDR_W-1:0] req_addr_x;
    logic [MAX_ADDR_W-1:0] load_addr_x;
    logic [MAX_ADDR_W-1:0] req_idx_full;
    logic [MAX_ADDR_W-1:0] load_idx_full;
    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      load_idx;
    logic                  req_ok;
    logic                  load_ok;
    logic                  accept;
    logic                  mem_we;
    logic                  mem_re;
    logic [WIDTH-1:0]      mem_rd_data;
    logic                  unused_idx_bits;

    logic                  resp_valid_q;
    logic [ADDR_W-1:0]     resp_addr_q;
    logic                  resp_err_q;
    logic                  resp_hit_q;
    logic                  load_err_q;

    assign req_addr_x    = MAX_ADDR_W'(ReqAddr);
    assign load_addr_x   = MAX_ADDR_W'(LoadAddr);
    assign req_idx_full  = idx_of(req_addr_x);
    assign load_idx_full = idx_of(load_addr_x);
    assign req_idx       = req_idx_full[IDX_W-1:0];
    assign load_idx      = load_idx_full[IDX_W-1:0];
    assign req_ok        = addr_ok(req_addr_x, DEPTH);
    assign load_ok       = addr_ok(load_addr_x, DEPTH);

    // The upper index bits only matter through addr_ok.
    assign unused_idx_bits = ^{req_idx_full[MAX_ADDR_W-1:IDX_W],
                               load_idx_full[MAX_ADDR_W-1:IDX_W]};

    // A load blocks fetches, so the memory never sees a read and a write in
    // the same cycle. Flush is deliberately kept out of ReqReady. The request
    // is simply not accepted.
    assign ReqReady = !LoadEn && (!resp_valid_q || RespReady);
    assign accept   = ReqValid && ReqReady && !Flush;

    assign mem_we = LoadEn && load_ok;
    assign mem_re = accept && req_ok;

    mem_sp_1r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (Clk),
        .we      (mem_we),
        .wr_idx  (load_idx),
        .wr_data (LoadData),
        .re      (mem_re),
        .rd_idx  (req_idx),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_hit_q   <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            if (Flush) begin
                resp_valid_q <= 1'b0;
            end else if (accept) begin
                resp_valid_q <= 1'b1;
                resp_addr_q  <= ReqAddr;
                resp_err_q   <= !req_ok;
                resp_hit_q   <= req_ok;
            end else if (resp_valid_q && RespReady) begin
                resp_valid_q <= 1'b0;
            end

            if (LoadEn && !load_ok) begin
                load_err_q <= 1'b1;
            end
        end
    end

    // The memory read register has no reset. resp_hit_q does, and it masks
    // that register to a NOP after reset and on any erroring fetch.
    assign RespInst  = resp_hit_q ? mem_rd_data : NOP_INST[WIDTH-1:0];
    assign RespValid = resp_valid_q;
    assign RespAddr  = resp_addr_q;
    assign RespErr   = resp_err_q;
    assign LoadErr   = load_err_q;

endmodule
